// File: rtl/note_input_conditioner_pkg.sv
// Shared definitions for the memory game's note input path: the press-tracking
// FSM state encoding, the default key count and the two debounce depths
// (short for simulation, full length for the board).
package note_input_conditioner_pkg;

    typedef enum logic [1:0] {
        WAIT_RELEASE = 2'd0,
        ARMED        = 2'd1,
        HELD         = 2'd2
    } note_state_t;

    localparam int NUM_KEYS_DEFAULT    = 4;
    localparam int DEBOUNCE_CYCLES_SIM = 5;
    localparam int DEBOUNCE_CYCLES_HW  = 500000;

endpackage : note_input_conditioner_pkg

// File: rtl/note_input_conditioner_key_debouncer.sv
// key_debouncer: one note key. Double-flop synchroniser on the active-low pin,
// inversion to active-high, and a stability counter. The debounced level only
// flips after DEBOUNCE_CYCLES consecutive synchronised cycles that disagree
// with it. o_idle reports that the key is settled (no change in progress).
module key_debouncer
    import note_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_raw_n,
    output logic o_level,
    output logic o_idle
);

    logic             r_sync1_n;
    logic             r_sync2_n;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             w_pressed;

    // Bring the asynchronous pin into the clk domain; resets to "released".
    // NOTE: sequential state is only ever assigned with <= so every flop sees
    // the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1_n <= 1'b1;
            r_sync2_n <= 1'b1;
        end else begin
            r_sync1_n <= i_key_raw_n;
            r_sync2_n <= r_sync1_n;
        end
    end

    assign w_pressed = ~r_sync2_n;

    // Count consecutive disagreeing cycles; accept the new level on the Nth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_level <= 1'b0;
        end else if (w_pressed == r_level) begin
            r_count <= '0;
        end else if (r_count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_count <= '0;
            r_level <= w_pressed;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_level = r_level;
    assign o_idle  = (w_pressed == r_level) && (r_count == '0);

endmodule : key_debouncer

// File: rtl/note_input_conditioner.sv
// note_input_conditioner: turns the raw active-low note buttons into clean,
// single-shot press events held in a one-entry valid/ack buffer, plus
// debounced key levels for LED echo.
// Build option: define NOTE_COND_CHORD_EN to accept simultaneous multi-key
// presses as one event; otherwise such a chord is rejected and flags overrun.
module note_input_conditioner
    import note_input_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                enable,
    output logic                press_valid,
    output logic [NUM_KEYS-1:0] press_note,
    input  logic                press_ack,
    output logic [NUM_KEYS-1:0] keys_level,
    output logic                overrun,
    input  logic                clear_err
);

    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_idle;
    logic [NUM_KEYS-1:0] r_level_prev;
    logic [NUM_KEYS-1:0] w_new_press;
    logic [1:0]          r_flush;
    logic                w_multi;
    logic                w_legal;
    logic                w_event;
    logic                w_drop;
    logic                w_chord_err;
    note_state_t         r_state;
    logic                r_press_valid;
    logic [NUM_KEYS-1:0] r_press_note;
    logic                r_overrun;

    for (genvar g_key = 0; g_key < NUM_KEYS; g_key++) begin : g_keys
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_key_debouncer (
            .clk        (clk),
            .reset      (reset),
            .i_key_raw_n(key_raw[g_key]),
            .o_level    (w_level[g_key]),
            .o_idle     (w_idle[g_key])
        );
    end

    // Previous debounced levels, for rising-edge (new press) detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_level_prev <= '0;
        else       r_level_prev <= w_level;
    end

    // After reset, hold off arming until the synchronisers have been refilled
    // with real pin values, so a key held through reset is seen as held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_flush <= 2'b00;
        else       r_flush <= {r_flush[0], 1'b1};
    end

    assign w_new_press = w_level & ~r_level_prev;
    assign w_multi     = |(w_new_press & (w_new_press - NUM_KEYS'(1)));

`ifdef NOTE_COND_CHORD_EN
    assign w_legal     = 1'b1;
    assign w_chord_err = 1'b0;
`else
    assign w_legal     = ~w_multi;
    assign w_chord_err = (r_state == ARMED) && enable && w_multi;
`endif

    assign w_event = (r_state == ARMED) && (|w_new_press) && enable && w_legal;
    assign w_drop  = w_event && r_press_valid && !press_ack;

    // Press-tracking FSM together with the event buffer and overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= WAIT_RELEASE;
            r_press_valid <= 1'b0;
            r_press_note  <= '0;
            r_overrun     <= 1'b0;
        end else begin
            // A same-cycle ack frees the slot, so the new event is taken.
            if (w_event && (!r_press_valid || press_ack)) begin
                r_press_valid <= 1'b1;
                r_press_note  <= w_new_press;
            end else if (r_press_valid && press_ack) begin
                r_press_valid <= 1'b0;
            end

            if (w_drop || w_chord_err) r_overrun <= 1'b1;
            else if (clear_err)        r_overrun <= 1'b0;

            case (r_state)
                WAIT_RELEASE: if (r_flush[1] && (w_level == '0) && (&w_idle)) r_state <= ARMED;
                ARMED:        if (|w_new_press)    r_state <= HELD;
                HELD:         if (w_level == '0)   r_state <= ARMED;
                default:                           r_state <= WAIT_RELEASE;
            endcase
        end
    end

    assign press_valid = r_press_valid;
    assign press_note  = r_press_note;
    assign keys_level  = w_level;
    assign overrun     = r_overrun;

endmodule : note_input_conditioner
